// File: rtl/upsp_wr_serializer_pkg.sv
// Shared definitions for the bicubic upsampler write-side serializer.
// Frame geometry here is shared with the bicubic stage so both agree on sizes.
package upsp_wr_serializer_pkg;

  // Pixel format and beat packing.
  localparam int PIXEL_WIDTH      = 24;
  localparam int PIX_PER_BEAT_DEF = 4;

  // Destination (upsampled) frame geometry.
  localparam int DST_WIDTH_DEF  = 3840;
  localparam int DST_HEIGHT_DEF = 2160;

  // Source frame geometry feeding the bicubic stage.
  localparam int SRC_WIDTH_DEF  = 1920;
  localparam int SRC_HEIGHT_DEF = 1080;

  // Occupancy of the single-beat holding register.
  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

  // Position flags for the pixel currently at the head of the stream.
  typedef struct packed {
    logic sof;  // column 0 of row 0
    logic eol;  // last column of any row
    logic eof;  // last column of the last row
  } frame_flags_t;

  // Counter width that stays at least one bit for degenerate sizes.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/upsp_frame_pos_cnt.sv
// Column/row position tracker for a raster-scanned frame.
// Advances one pixel per 'advance' pulse and wraps seamlessly at frame end.
module upsp_frame_pos_cnt
  import upsp_wr_serializer_pkg::*;
#(
  parameter int WIDTH  = DST_WIDTH_DEF,
  parameter int HEIGHT = DST_HEIGHT_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         advance,
  output frame_flags_t flags
);

  localparam int COL_W = cnt_width(WIDTH);
  localparam int ROW_W = cnt_width(HEIGHT);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;

  // Next position: step the column, carry into the row at end of line.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (which would infer a latch).
    col_d = col_q;
    row_d = row_q;
    if (advance) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Position registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // Flags describe the pixel that the next transfer will carry.
  always_comb begin
    flags     = '0;
    flags.sof = (col_q == '0) && (row_q == '0);
    flags.eol = (col_q == COL_LAST);
    flags.eof = (col_q == COL_LAST) && (row_q == ROW_LAST);
  end

endmodule

// File: rtl/upsp_wr_serializer.sv
// Serializes packed multi-pixel beats from the bicubic upsampler into a
// one-pixel-per-cycle AXI4-Stream with SOF (tuser) and EOL (tlast) framing.
module upsp_wr_serializer
  import upsp_wr_serializer_pkg::*;
#(
  parameter int PIXEL_WIDTH  = upsp_wr_serializer_pkg::PIXEL_WIDTH,
  parameter int PIX_PER_BEAT = PIX_PER_BEAT_DEF,
  parameter int DST_WIDTH    = DST_WIDTH_DEF,
  parameter int DST_HEIGHT   = DST_HEIGHT_DEF
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [PIXEL_WIDTH*PIX_PER_BEAT-1:0] upsp_ac_wdata,
  input  logic                              upsp_ac_wvalid,
  output logic                              ac_upsp_wready,
  output logic [PIXEL_WIDTH-1:0]            m_axis_tdata,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  output logic                              m_axis_tuser,
  output logic                              frame_done
);

  localparam int BEAT_W = PIXEL_WIDTH * PIX_PER_BEAT;
  localparam int LANE_W = cnt_width(PIX_PER_BEAT);

  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(PIX_PER_BEAT - 1);

  buf_state_e         state_q, state_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [LANE_W-1:0]  lane_q, lane_d;
  logic               frame_done_q, frame_done_d;

  logic               last_lane;
  logic               pix_xfer;
  logic               beat_take;
  frame_flags_t       pos_flags;

  // Raster position of the pixel at the head of the stream.
  upsp_frame_pos_cnt #(
    .WIDTH  (DST_WIDTH),
    .HEIGHT (DST_HEIGHT)
  ) u_pos (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (pix_xfer),
    .flags   (pos_flags)
  );

  // Handshake decode; wready frees up on the cycle the last lane drains so
  // back-to-back beats stream without a bubble. Held low while in reset.
  always_comb begin
    last_lane      = (lane_q == LANE_LAST);
    m_axis_tvalid  = (state_q == BUF_FULL);
    pix_xfer       = m_axis_tvalid && m_axis_tready;
    ac_upsp_wready = rst_n && ((state_q == BUF_EMPTY) || (m_axis_tready && last_lane));
    beat_take      = upsp_ac_wvalid && ac_upsp_wready;
  end

  // Lane mux and framing; all are functions of registered state, so they
  // hold steady while the downstream applies backpressure.
  always_comb begin
    m_axis_tdata = '0;
    for (int i = 0; i < PIX_PER_BEAT; i++) begin
      if (lane_q == LANE_W'(i)) begin
        m_axis_tdata = beat_q[i*PIXEL_WIDTH +: PIXEL_WIDTH];
      end
    end
    m_axis_tlast = m_axis_tvalid && pos_flags.eol;
    m_axis_tuser = m_axis_tvalid && pos_flags.sof;
    frame_done   = frame_done_q;
  end

  // Next-state: buffer occupancy, lane pointer, beat capture, frame-end pulse.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    lane_d       = lane_q;
    frame_done_d = pix_xfer && pos_flags.eof;

    if (pix_xfer) begin
      lane_d = last_lane ? '0 : lane_q + 1'b1;
      if (last_lane) begin
        state_d = BUF_EMPTY;
      end
    end

    // A new beat wins over the drain of the old one in the same cycle.
    if (beat_take) begin
      beat_d  = upsp_ac_wdata;
      state_d = BUF_FULL;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BUF_EMPTY;
      // NOTE: the beat register is reset too because it drives m_axis_tdata directly and outputs must read 0 in reset.
      beat_q       <= '0;
      lane_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      lane_q       <= lane_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_upsp_wr_serializer.sv
// Scoreboard bench for upsp_wr_serializer using an 8x2 frame.
module tb_upsp_wr_serializer;

  localparam int PW  = 24;
  localparam int PPB = 4;
  localparam int W   = 8;
  localparam int H   = 2;
  localparam int FRAME_PIX = W * H;

  typedef struct {
    logic [PW-1:0] data;
    logic          last;
    logic          user;
    logic          eof;
  } exp_pix_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [PW*PPB-1:0]  upsp_ac_wdata;
  logic               upsp_ac_wvalid;
  logic               ac_upsp_wready;
  logic [PW-1:0]      m_axis_tdata;
  logic               m_axis_tvalid;
  logic               m_axis_tready;
  logic               m_axis_tlast;
  logic               m_axis_tuser;
  logic               frame_done;

  int       checks   = 0;
  int       failures = 0;
  exp_pix_t sb[$];
  int       pix_idx  = 0;
  logic     fd_pending = 1'b0;

  upsp_wr_serializer #(
    .PIXEL_WIDTH  (PW),
    .PIX_PER_BEAT (PPB),
    .DST_WIDTH    (W),
    .DST_HEIGHT   (H)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .upsp_ac_wdata  (upsp_ac_wdata),
    .upsp_ac_wvalid (upsp_ac_wvalid),
    .ac_upsp_wready (ac_upsp_wready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tuser   (m_axis_tuser),
    .frame_done     (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected pixels of one beat: lane 0 first; tlast every W pixels, tuser on
  // pixel 0 of the frame, frame_done after the last pixel of the frame.
  task automatic push_beat(input logic [PW*PPB-1:0] data);
    exp_pix_t e;
    for (int i = 0; i < PPB; i++) begin
      e.data  = data[i*PW +: PW];
      e.last  = ((pix_idx % W) == W - 1);
      e.user  = (pix_idx == 0);
      e.eof   = (pix_idx == FRAME_PIX - 1);
      sb.push_back(e);
      pix_idx = (pix_idx + 1) % FRAME_PIX;
    end
  endtask

  // Offer a beat until accepted; returns 1 time unit after the accepting edge.
  task automatic send_beat(input logic [PW*PPB-1:0] data);
    logic acc;
    int   guard;
    acc   = 1'b0;
    guard = 0;
    upsp_ac_wdata  = data;
    upsp_ac_wvalid = 1'b1;
    while (!acc && guard < 200) begin
      @(negedge clk);
      acc = ac_upsp_wready;
      @(posedge clk);
      guard++;
    end
    if (!acc) check("accept_timeout", {31'd0, acc}, 32'd1);
    else      push_beat(data);
    #1 upsp_ac_wvalid = 1'b0;
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while ((m_axis_tvalid || sb.size() != 0) && g < 500) begin
      @(negedge clk);
      g++;
    end
    check("drain_left", sb.size(), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tvalid"},     {31'd0, m_axis_tvalid},  32'd0);
    check({tag, "_tlast"},      {31'd0, m_axis_tlast},   32'd0);
    check({tag, "_tuser"},      {31'd0, m_axis_tuser},   32'd0);
    check({tag, "_frame_done"}, {31'd0, frame_done},     32'd0);
    check({tag, "_wready"},     {31'd0, ac_upsp_wready}, 32'd0);
    check({tag, "_tdata"},      {8'd0, m_axis_tdata},    32'd0);
  endtask

  // Monitor: compare every transferred pixel against the scoreboard and
  // check frame_done against the pixel transferred one cycle earlier.
  always @(negedge clk) begin
    if (rst_n) begin
      logic     fd_next;
      exp_pix_t e;
      check("frame_done", {31'd0, frame_done}, {31'd0, fd_pending});
      fd_next = 1'b0;
      if (m_axis_tvalid && m_axis_tready) begin
        if (sb.size() == 0) begin
          check("unexpected_pixel", {8'd0, m_axis_tdata}, 32'hFFFFFFFF);
        end else begin
          e = sb.pop_front();
          check("tdata", {8'd0, m_axis_tdata}, {8'd0, e.data});
          check("tlast", {31'd0, m_axis_tlast}, {31'd0, e.last});
          check("tuser", {31'd0, m_axis_tuser}, {31'd0, e.user});
          fd_next = e.eof;
        end
      end
      fd_pending = fd_next;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    upsp_ac_wvalid = 1'b0;
    upsp_ac_wdata  = '0;
    m_axis_tready  = 1'b0;

    // 1. Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    #1 check("wready_after_release", {31'd0, ac_upsp_wready}, 32'd1);
    @(posedge clk);
    #1 m_axis_tready = 1'b1;

    // 2. Single beat, lanes 1..4, one-cycle latency to lane 0.
    send_beat({24'd4, 24'd3, 24'd2, 24'd1});
    @(negedge clk);
    check("latency_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
    check("latency_tdata",  {8'd0, m_axis_tdata},   32'd1);
    wait_drain();

    // 3. Four back-to-back beats: 16 gapless pixels, wready high on last lanes.
    //    This run crosses the frame end, so the wrap is seamless.
    fork
      begin
        for (int b = 0; b < 4; b++) begin
          send_beat({24'h10 + 24'(4*b+3), 24'h10 + 24'(4*b+2),
                     24'h10 + 24'(4*b+1), 24'h10 + 24'(4*b)});
        end
      end
      begin
        int g;
        g = 0;
        @(negedge clk);
        while (!m_axis_tvalid && g < 50) begin
          @(negedge clk);
          g++;
        end
        for (int c = 0; c < 16; c++) begin
          check("stream_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
          if (c % 4 == 3) check("stream_wready_last_lane", {31'd0, ac_upsp_wready}, 32'd1);
          if (c != 15) @(negedge clk);
        end
      end
    join
    wait_drain();

    // 4. Backpressure on lane 2, with the next beat already offered.
    send_beat({24'hA3, 24'hA2, 24'hA1, 24'hA0});
    repeat (2) @(posedge clk);
    #1 m_axis_tready = 1'b0;
    upsp_ac_wdata  = {24'hB3, 24'hB2, 24'hB1, 24'hB0};
    upsp_ac_wvalid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_tdata",  {8'd0, m_axis_tdata},     32'hA2);
      check("bp_tvalid", {31'd0, m_axis_tvalid},   32'd1);
      check("bp_wready", {31'd0, ac_upsp_wready},  32'd0);
    end
    @(posedge clk);
    #1 m_axis_tready = 1'b1;
    send_beat({24'hB3, 24'hB2, 24'hB1, 24'hB0});
    wait_drain();

    // 5. Framing from a clean frame start: ramp 0..15 then one more beat.
    rst_n = 1'b0;
    sb.delete();
    pix_idx    = 0;
    fd_pending = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int b = 0; b < 4; b++) begin
      send_beat({24'(4*b+3), 24'(4*b+2), 24'(4*b+1), 24'(4*b)});
    end
    send_beat({24'h103, 24'h102, 24'h101, 24'h100});
    wait_drain();

    // 6. Reset mid-beat after three pixels; partial beat is discarded.
    send_beat({24'hC3, 24'hC2, 24'hC1, 24'hC0});
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    sb.delete();
    pix_idx    = 0;
    fd_pending = 1'b0;
    #1 check_reset_outputs("mid_rst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 check("wready_after_mid_rst", {31'd0, ac_upsp_wready}, 32'd1);
    send_beat({24'hD3, 24'hD2, 24'hD1, 24'hD0});
    @(negedge clk);
    check("post_rst_lane0", {8'd0, m_axis_tdata},   32'hD0);
    check("post_rst_sof",   {31'd0, m_axis_tuser},  32'd1);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
